// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and defaults for the tristate bus arbiter.
// State encodings, default timing values, owner index width helper.
package tristate_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    localparam int TA_CYCLES_DEF = 1;
    localparam int MAX_HOLD_DEF  = 16;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr.
// Ports: req[N], ptr (search start) -> found, idx (winner index).
module rr_pick
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int OWNER_W = owner_w(N)
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               found,
    output logic [OWNER_W-1:0] idx
);

    int w_j;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_j = (int'(ptr) + i) % N;
            if (req[w_j]) begin
                found = 1'b1;
                idx   = OWNER_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with turnaround gap.
// Ports: Clk, Reset_n, req[N] -> enable[N], owner, busy, preempted.
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int  N         = 4,
    parameter int  TA_CYCLES = TA_CYCLES_DEF,
    parameter int  MAX_HOLD  = MAX_HOLD_DEF,
    localparam int OWNER_W   = owner_w(N)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [N-1:0]       req,
    output logic [N-1:0]       enable,
    output logic [OWNER_W-1:0] owner,
    output logic               busy,
    output logic               preempted
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [3:0] TA_LOAD = 4'(TA_CYCLES);

    arb_state_t          r_state;
    logic [N-1:0]        r_enable;
    logic [OWNER_W-1:0]  r_owner;
    logic                r_busy;
    logic                r_pre;
    logic [HOLD_W-1:0]   r_hold;
    logic [3:0]          r_gap;
    logic [OWNER_W-1:0]  r_ptr;

    arb_state_t          w_state_nx;
    logic [N-1:0]        w_enable_nx;
    logic [OWNER_W-1:0]  w_owner_nx;
    logic                w_busy_nx;
    logic                w_pre_nx;
    logic [HOLD_W-1:0]   w_hold_nx;
    logic [3:0]          w_gap_nx;
    logic [OWNER_W-1:0]  w_ptr_nx;

    logic                w_found;
    logic [OWNER_W-1:0]  w_idx;
    logic [N-1:0]        w_onehot;
    logic                w_others;
    logic                w_hold_hit;
    logic                w_take;
    logic                w_drop;

    rr_pick #(
        .N       (N),
        .OWNER_W (OWNER_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_idx] = 1'b1;
    end

    always_comb begin
        w_others = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i != int'(r_owner) && req[i]) w_others = 1'b1;
        end
    end

    // The hold counter saturates at its last value so a long solo
    // owner is released as soon as anyone else shows up.
    assign w_hold_hit = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);

    always_comb begin
        w_state_nx  = r_state;
        w_enable_nx = r_enable;
        w_owner_nx  = r_owner;
        w_busy_nx   = r_busy;
        w_pre_nx    = 1'b0;
        w_hold_nx   = r_hold;
        w_gap_nx    = r_gap;
        w_ptr_nx    = r_ptr;
        w_take      = 1'b0;
        w_drop      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_take = w_found;
            end
            ST_GRANT: begin
                if (!req[r_owner]) begin
                    w_drop = 1'b1;
                end else if (w_hold_hit && w_others) begin
                    w_drop   = 1'b1;
                    w_pre_nx = 1'b1;
                end else if (!w_hold_hit) begin
                    w_hold_nx = r_hold + 1'b1;
                end
            end
            ST_TURN: begin
                if (r_gap > 4'd1) begin
                    w_gap_nx = r_gap - 4'd1;
                end else begin
                    w_gap_nx = '0;
                    if (w_found) w_take = 1'b1;
                    else w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_take) begin
            w_state_nx  = ST_GRANT;
            w_enable_nx = w_onehot;
            w_busy_nx   = 1'b1;
            w_owner_nx  = w_idx;
            w_hold_nx   = '0;
            w_ptr_nx    = (w_idx == OWNER_W'(N - 1))
                        ? '0 : w_idx + 1'b1;
        end

        if (w_drop) begin
            w_state_nx  = ST_TURN;
            w_enable_nx = '0;
            w_busy_nx   = 1'b0;
            w_gap_nx    = TA_LOAD;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_IDLE;
            r_enable <= '0;
            r_owner  <= '0;
            r_busy   <= 1'b0;
            r_pre    <= 1'b0;
            r_hold   <= '0;
            r_gap    <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_enable <= w_enable_nx;
            r_owner  <= w_owner_nx;
            r_busy   <= w_busy_nx;
            r_pre    <= w_pre_nx;
            r_hold   <= w_hold_nx;
            r_gap    <= w_gap_nx;
            r_ptr    <= w_ptr_nx;
        end
    end

    assign enable    = r_enable;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign preempted = r_pre;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: three instances, shared req.
// Behavioural owner/gap model compared every cycle plus directed cases.
module tb_tristate_bus_arbiter;

    localparam int N  = 4;
    localparam int NI = 3;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic [N-1:0] req;
    logic [N-1:0] en   [NI];
    logic [1:0]   own  [NI];
    logic         busy [NI];
    logic         pre  [NI];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    tristate_bus_arbiter #(.N(N), .TA_CYCLES(2), .MAX_HOLD(16)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .enable(en[0]),
        .owner(own[0]), .busy(busy[0]), .preempted(pre[0]));

    tristate_bus_arbiter #(.N(N), .TA_CYCLES(1), .MAX_HOLD(4)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .enable(en[1]),
        .owner(own[1]), .busy(busy[1]), .preempted(pre[1]));

    tristate_bus_arbiter #(.N(N), .TA_CYCLES(3), .MAX_HOLD(0)) u_c (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .enable(en[2]),
        .owner(own[2]), .busy(busy[2]), .preempted(pre[2]));

    function automatic int ta_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int mh_of(input int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: owner index (-1 = bus undriven), cycles owned so far,
    // undriven cycles still owed, last granted index.
    int m_own  [NI];
    int m_held [NI];
    int m_gap  [NI];
    int m_last [NI];
    bit m_pre  [NI];

    task automatic model_step(input int k);
        bit others;
        bit got;
        int j;
        m_pre[k] = 1'b0;
        if (m_own[k] >= 0) begin
            m_held[k]++;
            others = 1'b0;
            for (int i = 0; i < N; i++)
                if (i != m_own[k] && req[i]) others = 1'b1;
            if (!req[m_own[k]]) begin
                m_own[k] = -1;
                m_gap[k] = ta_of(k);
            end else if (mh_of(k) != 0 && m_held[k] >= mh_of(k)
                         && others) begin
                m_own[k] = -1;
                m_gap[k] = ta_of(k);
                m_pre[k] = 1'b1;
            end
        end else begin
            if (m_gap[k] > 0) m_gap[k]--;
            if (m_gap[k] == 0 && req != '0) begin
                got = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    j = (m_last[k] + i) % N;
                    if (!got && req[j]) begin
                        got = 1'b1;
                        m_own[k] = j;
                    end
                end
                m_last[k] = m_own[k];
                m_held[k] = 0;
            end
        end
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!Reset_n) begin
                m_own[k]  = -1;
                m_held[k] = 0;
                m_gap[k]  = 0;
                m_last[k] = N - 1;
                m_pre[k]  = 1'b0;
            end else begin
                model_step(k);
            end
        end
    end

    function automatic logic [3:0] exp_en(input int k);
        if (m_own[k] < 0) return 4'b0000;
        return 4'(1 << m_own[k]);
    endfunction

    int         zeros   [NI];
    bit         seen    [NI];
    logic [3:0] prev_en [NI];

    always @(negedge Clk) begin
        for (int k = 0; k < NI; k++) begin
            check($sformatf("en%0d", k), en[k], exp_en(k));
            check($sformatf("busy%0d", k), busy[k], m_own[k] >= 0);
            check($sformatf("pre%0d", k), pre[k], m_pre[k]);
            if (m_own[k] >= 0)
                check($sformatf("owner%0d", k), own[k], m_own[k]);
            check($sformatf("onehot%0d", k), $onehot0(en[k]), 1);
            if (!Reset_n) begin
                seen[k]  = 1'b0;
                zeros[k] = 0;
            end else begin
                if (en[k] != '0 && en[k] != prev_en[k] && seen[k])
                    check($sformatf("gap%0d", k), zeros[k] >= ta_of(k), 1);
                if (en[k] != '0) begin
                    zeros[k] = 0;
                    seen[k]  = 1'b1;
                end else begin
                    zeros[k]++;
                end
            end
            prev_en[k] = en[k];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int order[$];
    int own_cnt;
    int exp_order[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        Reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge Clk);
        check("rst_en", en[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_owner", own[0], 0);
        check("rst_pre", pre[0], 0);

        #2 Reset_n = 1'b1;
        req = 4'b0100;
        @(negedge Clk);
        check("single_en", en[0], 4'b0100);
        check("single_owner", own[0], 2);
        check("single_busy", busy[0], 1);

        req = '0;
        repeat (8) @(negedge Clk);

        req = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("handover_own0", en[0], 4'b0001);
        end
        req = 4'b0010;
        @(negedge Clk);
        check("handover_gap1", en[0], 4'b0000);
        @(negedge Clk);
        check("handover_gap2", en[0], 4'b0000);
        @(negedge Clk);
        check("handover_own1", en[0], 4'b0010);

        own_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            if (busy[0]) begin
                own_cnt++;
                if (own_cnt == 1) order.push_back(int'(own[0]));
                if (own_cnt >= 3) req = 4'hF & ~(4'b0001 << own[0]);
                else req = 4'hF;
            end else begin
                own_cnt = 0;
                req     = 4'hF;
            end
            @(negedge Clk);
        end
        check("rr_count", order.size() >= 8, 1);
        for (int i = 0; i < 8; i++)
            if (i < order.size())
                check($sformatf("rr_order%0d", i), order[i], exp_order[i]);

        req = '0;
        repeat (10) @(negedge Clk);
        req = 4'b0100;
        @(negedge Clk);
        check("preempt_c1", en[1], 4'b0100);
        check("nohold_c1", en[2], 4'b0100);
        req = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("preempt_hold", en[1], 4'b0100);
        end
        @(negedge Clk);
        check("preempt_gap", en[1], 4'b0000);
        check("preempt_pulse", pre[1], 1);
        @(negedge Clk);
        check("preempt_next", en[1], 4'b1000);
        check("preempt_clear", pre[1], 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check("nohold_keep", en[2], 4'b0100);
            check("nohold_pre", pre[2], 0);
        end

        req = '0;
        repeat (10) @(negedge Clk);
        req = 4'b0001;
        repeat (2) @(negedge Clk);
        check("mid_busy", busy[0], 1);
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("async_en0", en[0], 0);
        check("async_en1", en[1], 0);
        check("async_en2", en[2], 0);
        req = 4'b1010;
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        @(negedge Clk);
        check("ptr_reset_en", en[0], 4'b0010);
        check("ptr_reset_owner", own[0], 1);

        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            @(negedge Clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
